// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM -> data memory (req/ack) -> MEM/WB; 1 cycle for non-memory ops.
// Memory ops stall upstream for ack-delay+2 cycles; an access with no ack is aborted after TIMEOUT_CYC cycles.
module mem_stage #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk_i,
   input  logic        start_i,
   input  logic        RegWrite_i,
   input  logic        MemToReg_i,
   input  logic [1:0]  MemRead_i,
   input  logic [1:0]  MemWrite_i,
   input  logic [31:0] ALUdata_i,
   input  logic [31:0] WriteData_i,
   input  logic [4:0]  RegAddr_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        stall_o,
   output logic        RegWrite_o,
   output logic        MemToReg_o,
   output logic [4:0]  RegAddr_o,
   output logic [31:0] ALUdata_o,
   output logic [31:0] MemData_o,
   output logic        error_o
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [1:0] SZ_WORD = 2'd1;
   localparam logic [1:0] SZ_HALF = 2'd2;
   localparam logic [1:0] SZ_BYTE = 2'd3;
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

   state_t      state, state_nxt;
   logic        stall;
   logic        is_mem, illegal, misaligned, bad_op;
   logic [1:0]  acc_sz;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [1:0]  ld_sz, ld_off;
   logic [15:0] half_sel;
   logic [7:0]  byte_sel;
   logic [31:0] ld_ext;
   logic [31:0] rd_buf;
   logic [7:0]  to_cnt;
   logic        timeout;
   logic        kill_rw;

   // Access classification of the instruction currently in EX/MEM
   always_comb begin
      is_mem     = (MemRead_i != 2'd0) || (MemWrite_i != 2'd0);
      illegal    = (MemRead_i != 2'd0) && (MemWrite_i != 2'd0);
      acc_sz     = (MemRead_i != 2'd0) ? MemRead_i : MemWrite_i;
      misaligned = ((acc_sz == SZ_WORD) && (ALUdata_i[1:0] != 2'd0)) ||
                   ((acc_sz == SZ_HALF) && ALUdata_i[0]);
      bad_op     = is_mem && (illegal || misaligned);
   end

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = 32'd0;
      case (MemWrite_i)
         SZ_WORD: begin
            st_be    = 4'b1111;
            st_wdata = WriteData_i;
         end
         SZ_HALF: begin
            st_be    = 4'b0011 << {ALUdata_i[1], 1'b0};
            st_wdata = {2{WriteData_i[15:0]}};
         end
         SZ_BYTE: begin
            st_be    = 4'b0001 << ALUdata_i[1:0];
            st_wdata = {4{WriteData_i[7:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = 32'd0;
         end
      endcase
   end

   // Lane select uses the latched offset; stores latch ld_sz = 0 and so buffer zero
   always_comb begin
      half_sel = ld_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (ld_off)
         2'd0:    byte_sel = mem_rdata_i[7:0];
         2'd1:    byte_sel = mem_rdata_i[15:8];
         2'd2:    byte_sel = mem_rdata_i[23:16];
         default: byte_sel = mem_rdata_i[31:24];
      endcase
      case (ld_sz)
         SZ_WORD: ld_ext = mem_rdata_i;
         SZ_HALF: ld_ext = {{16{half_sel[15]}}, half_sel};
         SZ_BYTE: ld_ext = {{24{byte_sel[7]}}, byte_sel};
         default: ld_ext = 32'd0;
      endcase
   end

   assign timeout = (to_cnt == TO_LAST);

   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (is_mem && !bad_op) begin
               stall     = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (mem_ack_i || timeout) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Gated so every output reads 0 while reset is held
   assign stall_o = stall & start_i;

   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         state       <= IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= 32'd0;
         mem_be_o    <= 4'd0;
         mem_wdata_o <= 32'd0;
         RegWrite_o  <= 1'b0;
         MemToReg_o  <= 1'b0;
         RegAddr_o   <= 5'd0;
         ALUdata_o   <= 32'd0;
         MemData_o   <= 32'd0;
         error_o     <= 1'b0;
         ld_sz       <= 2'd0;
         ld_off      <= 2'd0;
         rd_buf      <= 32'd0;
         to_cnt      <= 8'd0;
         kill_rw     <= 1'b0;
      end else begin
         state   <= state_nxt;
         error_o <= 1'b0;
         case (state)
            IDLE: begin
               if (!is_mem || bad_op) begin
                  RegWrite_o <= RegWrite_i & ~bad_op;
                  MemToReg_o <= MemToReg_i;
                  RegAddr_o  <= RegAddr_i;
                  ALUdata_o  <= ALUdata_i;
                  MemData_o  <= 32'd0;
                  error_o    <= bad_op;
               end else begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= (MemWrite_i != 2'd0);
                  mem_addr_o  <= {ALUdata_i[31:2], 2'b00};
                  mem_be_o    <= st_be;
                  mem_wdata_o <= st_wdata;
                  ld_sz       <= MemRead_i;
                  ld_off      <= ALUdata_i[1:0];
                  to_cnt      <= 8'd0;
                  kill_rw     <= 1'b0;
                  RegWrite_o  <= 1'b0;
                  MemToReg_o  <= 1'b0;
               end
            end
            ACCESS: begin
               RegWrite_o <= 1'b0;
               MemToReg_o <= 1'b0;
               if (mem_ack_i) begin
                  mem_req_o <= 1'b0;
                  rd_buf    <= ld_ext;
               end else if (timeout) begin
                  mem_req_o <= 1'b0;
                  rd_buf    <= 32'd0;
                  error_o   <= 1'b1;
                  kill_rw   <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            DONE: begin
               RegWrite_o <= RegWrite_i & ~kill_rw;
               MemToReg_o <= MemToReg_i;
               RegAddr_o  <= RegAddr_i;
               ALUdata_o  <= ALUdata_i;
               MemData_o  <= rd_buf;
            end
            default: begin
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with expected request/write-back queues checked by a monitor.
module tb_mem_stage;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic        rw;
      logic        mtr;
      logic [4:0]  ra;
      logic [31:0] alu;
      logic [31:0] md;
   } wb_t;

   logic        clk_i = 1'b0;
   logic        start_i;
   logic        RegWrite_i, MemToReg_i;
   logic [1:0]  MemRead_i, MemWrite_i;
   logic [31:0] ALUdata_i, WriteData_i;
   logic [4:0]  RegAddr_i;
   logic        mem_req_o, mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic        stall_o;
   logic        RegWrite_o, MemToReg_o;
   logic [4:0]  RegAddr_o;
   logic [31:0] ALUdata_o, MemData_o;
   logic        error_o;

   always #5 clk_i = ~clk_i;

   mem_stage #(.TIMEOUT_CYC(4)) dut (
      .clk_i(clk_i), .start_i(start_i),
      .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
      .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
      .ALUdata_i(ALUdata_i), .WriteData_i(WriteData_i), .RegAddr_i(RegAddr_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
      .RegAddr_o(RegAddr_o), .ALUdata_o(ALUdata_o), .MemData_o(MemData_o),
      .error_o(error_o)
   );

   req_t        exp_req_q[$];
   wb_t         exp_wb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          stall_cnt = 0;
   int          req_cnt = 0;
   int          err_cnt = 0;
   logic        ins_vld = 1'b0;
   int          ack_dly = 1000;
   logic [31:0] rdata_model = 32'd0;
   logic        wb_pend = 1'b0;
   logic        bub_pend = 1'b0;
   logic        prev_req = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Memory model: ack arrives ack_dly cycles after the request rises
   initial begin
      int age;
      age = 0;
      mem_ack_i = 1'b0;
      mem_rdata_i = 32'd0;
      forever begin
         @(posedge clk_i);
         #1;
         mem_rdata_i = rdata_model;
         mem_ack_i = (mem_req_o === 1'b1) && (age == ack_dly);
         age = (mem_req_o === 1'b1) ? age + 1 : 0;
      end
   end

   // Monitor: pops expected requests on request rise and expected write-backs after each accept
   initial begin
      wb_t  w;
      req_t r;
      forever begin
         @(negedge clk_i);
         if (start_i !== 1'b1) begin
            wb_pend = 1'b0;
            bub_pend = 1'b0;
            prev_req = 1'b0;
         end else begin
            if (wb_pend) begin
               if (exp_wb_q.size() == 0) begin
                  check("wb_unexpected", 32'd1, 32'd0);
               end else begin
                  w = exp_wb_q.pop_front();
                  check("wb_regwrite", RegWrite_o, w.rw);
                  check("wb_memtoreg", MemToReg_o, w.mtr);
                  check("wb_regaddr", RegAddr_o, w.ra);
                  check("wb_aludata", ALUdata_o, w.alu);
                  check("wb_memdata", MemData_o, w.md);
               end
            end
            if (bub_pend) begin
               check("bubble_regwrite", RegWrite_o, 32'd0);
               check("bubble_memtoreg", MemToReg_o, 32'd0);
            end
            if (mem_req_o && !prev_req) begin
               if (exp_req_q.size() == 0) begin
                  check("req_unexpected", 32'd1, 32'd0);
               end else begin
                  r = exp_req_q.pop_front();
                  check("req_addr", mem_addr_o, r.addr);
                  check("req_be", mem_be_o, r.be);
                  check("req_we", mem_we_o, r.we);
                  check("req_wdata", mem_wdata_o, r.wdata);
               end
            end
            prev_req = mem_req_o;
            stall_cnt += int'(stall_o);
            req_cnt += int'(mem_req_o);
            err_cnt += int'(error_o);
            wb_pend = ins_vld && !stall_o;
            bub_pend = ins_vld && stall_o;
         end
      end
   end

   task automatic drive_nop();
      ins_vld = 1'b0;
      MemRead_i = 2'd0;
      MemWrite_i = 2'd0;
      RegWrite_i = 1'b0;
      MemToReg_i = 1'b0;
      ALUdata_i = 32'd0;
      WriteData_i = 32'd0;
      RegAddr_i = 5'd0;
   endtask

   task automatic issue(input string name, input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic rw,
                        input logic mtr, input logic [4:0] ra, input int dly,
                        input logic [31:0] rdat, input logic has_req, input req_t er,
                        input wb_t ew, input int e_stall, input int e_req, input int e_err);
      int s0, r0, e0, cyc;
      @(posedge clk_i);
      #1;
      ack_dly = dly;
      rdata_model = rdat;
      if (has_req) exp_req_q.push_back(er);
      exp_wb_q.push_back(ew);
      s0 = stall_cnt;
      r0 = req_cnt;
      e0 = err_cnt;
      MemRead_i = rd;
      MemWrite_i = wr;
      ALUdata_i = addr;
      WriteData_i = wd;
      RegWrite_i = rw;
      MemToReg_i = mtr;
      RegAddr_i = ra;
      ins_vld = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk_i);
         cyc++;
      end while (stall_o && cyc < 50);
      check({name, "_accept"}, stall_o, 32'd0);
      @(posedge clk_i);
      #1;
      drive_nop();
      ack_dly = 1000;
      repeat (2) @(posedge clk_i);
      #1;
      check({name, "_stall_cycles"}, stall_cnt - s0, e_stall);
      check({name, "_req_cycles"}, req_cnt - r0, e_req);
      check({name, "_error_pulses"}, err_cnt - e0, e_err);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_nop();
      start_i = 1'b1;
      #2 start_i = 1'b0;
      #2;
      check("reset_req", mem_req_o, 32'd0);
      check("reset_stall", stall_o, 32'd0);
      check("reset_error", error_o, 32'd0);
      check("reset_regwrite", RegWrite_o, 32'd0);
      check("reset_memdata", MemData_o, 32'd0);
      repeat (2) @(posedge clk_i);
      #1 start_i = 1'b1;

      issue("add", 2'd0, 2'd0, 32'h1234, 32'd0, 1'b1, 1'b0, 5'd5, 1000, 32'd0,
            1'b0, req_t'{32'd0, 4'd0, 1'b0, 32'd0},
            wb_t'{1'b1, 1'b0, 5'd5, 32'h1234, 32'd0}, 0, 0, 0);
      issue("lw", 2'd1, 2'd0, 32'h40, 32'd0, 1'b1, 1'b1, 5'd7, 3, 32'hDEADBEEF,
            1'b1, req_t'{32'h40, 4'hF, 1'b0, 32'd0},
            wb_t'{1'b1, 1'b1, 5'd7, 32'h40, 32'hDEADBEEF}, 5, 4, 0);
      issue("sb", 2'd0, 2'd3, 32'h103, 32'h000000A5, 1'b0, 1'b0, 5'd0, 0, 32'h11111111,
            1'b1, req_t'{32'h100, 4'b1000, 1'b1, 32'hA5A5A5A5},
            wb_t'{1'b0, 1'b0, 5'd0, 32'h103, 32'd0}, 2, 1, 0);
      issue("lh", 2'd2, 2'd0, 32'h22, 32'd0, 1'b1, 1'b1, 5'd9, 1, 32'h80011234,
            1'b1, req_t'{32'h20, 4'hF, 1'b0, 32'd0},
            wb_t'{1'b1, 1'b1, 5'd9, 32'h22, 32'hFFFF8001}, 3, 2, 0);
      issue("lb", 2'd3, 2'd0, 32'h20, 32'd0, 1'b1, 1'b1, 5'd10, 0, 32'h5566337F,
            1'b1, req_t'{32'h20, 4'hF, 1'b0, 32'd0},
            wb_t'{1'b1, 1'b1, 5'd10, 32'h20, 32'h0000007F}, 2, 1, 0);
      issue("lb_neg", 2'd3, 2'd0, 32'h21, 32'd0, 1'b1, 1'b1, 5'd11, 0, 32'h00008000,
            1'b1, req_t'{32'h20, 4'hF, 1'b0, 32'd0},
            wb_t'{1'b1, 1'b1, 5'd11, 32'h21, 32'hFFFFFF80}, 2, 1, 0);
      issue("lw_misaligned", 2'd1, 2'd0, 32'h42, 32'd0, 1'b1, 1'b1, 5'd3, 0, 32'd0,
            1'b0, req_t'{32'd0, 4'd0, 1'b0, 32'd0},
            wb_t'{1'b0, 1'b1, 5'd3, 32'h42, 32'd0}, 0, 0, 1);
      issue("illegal", 2'd1, 2'd1, 32'h50, 32'd0, 1'b1, 1'b0, 5'd4, 0, 32'd0,
            1'b0, req_t'{32'd0, 4'd0, 1'b0, 32'd0},
            wb_t'{1'b0, 1'b0, 5'd4, 32'h50, 32'd0}, 0, 0, 1);
      issue("timeout", 2'd1, 2'd0, 32'h60, 32'd0, 1'b1, 1'b1, 5'd6, 1000, 32'hCAFEF00D,
            1'b1, req_t'{32'h60, 4'hF, 1'b0, 32'd0},
            wb_t'{1'b0, 1'b1, 5'd6, 32'h60, 32'd0}, 5, 4, 1);
      issue("sh", 2'd0, 2'd2, 32'h12, 32'h0000BEEF, 1'b0, 1'b0, 5'd0, 2, 32'd0,
            1'b1, req_t'{32'h10, 4'b1100, 1'b1, 32'hBEEFBEEF},
            wb_t'{1'b0, 1'b0, 5'd0, 32'h12, 32'd0}, 4, 3, 0);
      issue("sw", 2'd0, 2'd1, 32'h80, 32'h12345678, 1'b0, 1'b0, 5'd0, 0, 32'd0,
            1'b1, req_t'{32'h80, 4'hF, 1'b1, 32'h12345678},
            wb_t'{1'b0, 1'b0, 5'd0, 32'h80, 32'd0}, 2, 1, 0);

      // Reset in the middle of an access that is never acked
      @(posedge clk_i);
      #1;
      ack_dly = 1000;
      exp_req_q.push_back(req_t'{32'h70, 4'hF, 1'b0, 32'd0});
      MemRead_i = 2'd1;
      ALUdata_i = 32'h70;
      RegWrite_i = 1'b1;
      MemToReg_i = 1'b1;
      RegAddr_i = 5'd8;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_pre_req", mem_req_o, 32'd1);
      start_i = 1'b0;
      #1;
      check("rst_req", mem_req_o, 32'd0);
      check("rst_we", mem_we_o, 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_be", mem_be_o, 32'd0);
      check("rst_wdata", mem_wdata_o, 32'd0);
      check("rst_stall", stall_o, 32'd0);
      check("rst_regwrite", RegWrite_o, 32'd0);
      check("rst_memtoreg", MemToReg_o, 32'd0);
      check("rst_regaddr", RegAddr_o, 32'd0);
      check("rst_aludata", ALUdata_o, 32'd0);
      check("rst_memdata", MemData_o, 32'd0);
      check("rst_error", error_o, 32'd0);
      drive_nop();
      @(posedge clk_i);
      #1 start_i = 1'b1;

      issue("post_rst_add", 2'd0, 2'd0, 32'h5678, 32'd0, 1'b1, 1'b0, 5'd12, 1000, 32'd0,
            1'b0, req_t'{32'd0, 4'd0, 1'b0, 32'd0},
            wb_t'{1'b1, 1'b0, 5'd12, 32'h5678, 32'd0}, 0, 0, 0);

      repeat (3) @(posedge clk_i);
      #1;
      check("wb_queue_drained", exp_wb_q.size(), 32'd0);
      check("req_queue_drained", exp_req_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
